writeback_stage: RTL and testbench

Final pipeline stage of the RV32I core and the producer end of the decode stage's register-file write port. Holds the MEM/WB pipeline register, aligns and sign- or zero-extends load data, and selects the write-back result. Drives `o_rd_wren` / `o_rd_addr` / `o_rd_data` straight into the decode stage's `i_rd_wren` / `i_rd_addr` / `i_rd_data`.

---
 rtl/pipeline_pkg.sv | 33 +++
 rtl/writeback_stage_if.sv | 56 +++++
 rtl/wb_load_align.sv | 43 ++++
 rtl/writeback_stage.sv | 88 ++++++++
 tb/tb_writeback_stage.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the RV32I core.
//   wb_sel_e  : write-back result source (encoding 2'b11 is reserved, treated as ALU)
//   F3_*      : load funct3 codes understood by the load aligner
//   mem_wb_t  : MEM/WB pipeline register contents
package pipeline_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic            valid;
        logic            rd_wren;
        logic [4:0]      rd_addr;
        wb_sel_e         wb_sel;
        logic [2:0]      funct3;
        logic [1:0]      addr_lo;
        logic [XLEN-1:0] alu_data;
        logic [XLEN-1:0] ld_data;
        logic [XLEN-1:0] pc_four;
    } mem_wb_t;

endpackage

// File: rtl/writeback_stage_if.sv
// Pipeline-side bundle of the write-back stage.
// Optional feature macro: WB_RETIRE_CNT_EN adds the o_insn_cnt retire counter.
//   i_stall/i_flush          : MEM/WB hold and bubble controls
//   i_valid .. i_pc_four     : instruction fields arriving from MEM
//   o_rd_wren/addr/data      : register-file write port (to decode stage)
//   o_retire                 : a valid instruction completes this cycle
//   o_insn_cnt               : 64-bit retired-instruction count (macro only)
// master = producer of the i_* fields, slave = the write-back stage itself.
interface writeback_stage_if;
    import pipeline_pkg::*;

    logic            i_stall;
    logic            i_flush;
    logic            i_valid;
    logic            i_rd_wren;
    logic [4:0]      i_rd_addr;
    logic [1:0]      i_wb_sel;
    logic [2:0]      i_funct3;
    logic [1:0]      i_addr_lo;
    logic [XLEN-1:0] i_alu_data;
    logic [XLEN-1:0] i_ld_data;
    logic [XLEN-1:0] i_pc_four;

    logic            o_rd_wren;
    logic [4:0]      o_rd_addr;
    logic [XLEN-1:0] o_rd_data;
    logic            o_retire;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0]     o_insn_cnt;
`endif

`ifdef WB_RETIRE_CNT_EN
    modport master (
        output i_stall, i_flush, i_valid, i_rd_wren, i_rd_addr, i_wb_sel,
        output i_funct3, i_addr_lo, i_alu_data, i_ld_data, i_pc_four,
        input  o_rd_wren, o_rd_addr, o_rd_data, o_retire, o_insn_cnt
    );
    modport slave (
        input  i_stall, i_flush, i_valid, i_rd_wren, i_rd_addr, i_wb_sel,
        input  i_funct3, i_addr_lo, i_alu_data, i_ld_data, i_pc_four,
        output o_rd_wren, o_rd_addr, o_rd_data, o_retire, o_insn_cnt
    );
`else
    modport master (
        output i_stall, i_flush, i_valid, i_rd_wren, i_rd_addr, i_wb_sel,
        output i_funct3, i_addr_lo, i_alu_data, i_ld_data, i_pc_four,
        input  o_rd_wren, o_rd_addr, o_rd_data, o_retire
    );
    modport slave (
        input  i_stall, i_flush, i_valid, i_rd_wren, i_rd_addr, i_wb_sel,
        input  i_funct3, i_addr_lo, i_alu_data, i_ld_data, i_pc_four,
        output o_rd_wren, o_rd_addr, o_rd_data, o_retire
    );
`endif

endinterface

// File: rtl/wb_load_align.sv
// Load-data aligner: picks the addressed byte/halfword out of a raw aligned
// word and sign- or zero-extends it according to the load funct3.
//   funct3  : load width/sign (LB, LH, LW, LBU, LHU; other codes pass the word)
//   addr_lo : byte offset; only bit 1 matters for halfwords
//   ld_data : raw aligned word from the LSU
//   ld_ext  : extended 32-bit result
// Purely combinational; also instantiated by the LSU for forwarding checks.
module wb_load_align
    import pipeline_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] ld_data,
    output logic [XLEN-1:0] ld_ext
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        unique case (addr_lo)
            2'd0: ld_byte = ld_data[7:0];
            2'd1: ld_byte = ld_data[15:8];
            2'd2: ld_byte = ld_data[23:16];
            2'd3: ld_byte = ld_data[31:24];
        endcase
    end

    // addr_lo[0] is deliberately ignored: misaligned halfwords are not trapped here.
    assign ld_half = addr_lo[1] ? ld_data[31:16] : ld_data[15:0];

    always_comb begin
        case (funct3)
            F3_LB:   ld_ext = {{24{ld_byte[7]}}, ld_byte};
            F3_LH:   ld_ext = {{16{ld_half[15]}}, ld_half};
            F3_LW:   ld_ext = ld_data;
            F3_LBU:  ld_ext = {24'd0, ld_byte};
            F3_LHU:  ld_ext = {16'd0, ld_half};
            default: ld_ext = ld_data;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Final RV32I pipeline stage: MEM/WB register, load extraction and result
// select, driving the decode stage's register-file write port.
// Optional feature macro: WB_RETIRE_CNT_EN (64-bit retired-instruction counter
// on o_insn_cnt; absent when undefined).
//   i_clk : clock, rising edge
//   i_rst : asynchronous active-low reset
//   wb    : writeback_stage_if.slave (stall/flush, instruction fields, rd port,
//           o_retire, optional o_insn_cnt)
// Every output is decoded from the MEM/WB register; only i_stall reaches an
// output combinationally (o_retire).
module writeback_stage
    import pipeline_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    writeback_stage_if.slave  wb
);

    mem_wb_t         mem_wb_d;
    mem_wb_t         mem_wb_q;
    logic [XLEN-1:0] ld_ext;
    logic [XLEN-1:0] rd_data;
    logic            retire;

    always_comb begin
        mem_wb_d          = '0;
        mem_wb_d.valid    = wb.i_valid;
        mem_wb_d.rd_wren  = wb.i_rd_wren;
        mem_wb_d.rd_addr  = wb.i_rd_addr;
        // 2'b11 is carried through unchanged and falls into the ALU default below.
        mem_wb_d.wb_sel   = wb_sel_e'(wb.i_wb_sel);
        mem_wb_d.funct3   = wb.i_funct3;
        mem_wb_d.addr_lo  = wb.i_addr_lo;
        mem_wb_d.alu_data = wb.i_alu_data;
        mem_wb_d.ld_data  = wb.i_ld_data;
        mem_wb_d.pc_four  = wb.i_pc_four;
    end

    // Flush wins over stall; a flushed entry keeps its payload but never writes or retires.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            mem_wb_q <= '0;
        end else if (wb.i_flush) begin
            mem_wb_q.valid <= 1'b0;
        end else if (!wb.i_stall) begin
            mem_wb_q <= mem_wb_d;
        end
    end

    wb_load_align u_load_align (
        .funct3  (mem_wb_q.funct3),
        .addr_lo (mem_wb_q.addr_lo),
        .ld_data (mem_wb_q.ld_data),
        .ld_ext  (ld_ext)
    );

    always_comb begin
        case (mem_wb_q.wb_sel)
            WB_LOAD: rd_data = ld_ext;
            WB_PC4:  rd_data = mem_wb_q.pc_four;
            default: rd_data = mem_wb_q.alu_data;
        endcase
    end

    // A stalled entry retires once, in the cycle the stall drops.
    assign retire       = mem_wb_q.valid & ~wb.i_stall;

    // x0 writes are dropped here so the register file never sees them.
    assign wb.o_rd_wren = mem_wb_q.valid & mem_wb_q.rd_wren & (mem_wb_q.rd_addr != 5'd0);
    assign wb.o_rd_addr = mem_wb_q.rd_addr;
    assign wb.o_rd_data = rd_data;
    assign wb.o_retire  = retire;

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] insn_cnt_q;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            insn_cnt_q <= 64'd0;
        end else if (retire) begin
            insn_cnt_q <= insn_cnt_q + 64'd1;
        end
    end

    assign wb.o_insn_cnt = insn_cnt_q;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed cases followed by random
// stimulus compared against a behavioural model of the stage.
module tb_writeback_stage;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    // Model of the instruction currently held in MEM/WB.
    bit          m_valid;
    bit          m_known;   // payload defined (cleared by a flush)
    bit          m_wren;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [63:0] m_cnt;

    writeback_stage_if wb_if ();

    writeback_stage u_dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .wb    (wb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference result from the architectural load/write-back rules.
    function automatic logic [31:0] model_result(input logic [1:0] sel, input logic [2:0] f3,
                                                 input logic [1:0] alo, input logic [31:0] alu,
                                                 input logic [31:0] ld, input logic [31:0] pc4);
        logic [31:0] b;
        logic [31:0] h;
        b = (ld >> (8 * alo)) & 32'hFF;
        h = (ld >> (16 * alo[1])) & 32'hFFFF;
        if (sel == 2'd2) return pc4;
        if (sel != 2'd1) return alu;
        if (f3 == 3'd0) return (b >= 128) ? b + 32'hFFFF_FF00 : b;
        if (f3 == 3'd1) return (h >= 32768) ? h + 32'hFFFF_0000 : h;
        if (f3 == 3'd4) return b;
        if (f3 == 3'd5) return h;
        return ld;
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_known = 1;
        m_wren  = 0;
        m_addr  = '0;
        m_data  = '0;
        m_cnt   = '0;
    endtask

    task automatic check_outputs(input logic stall);
        check_eq("rd_wren", wb_if.o_rd_wren, m_valid && m_wren && (m_addr != 0));
        check_eq("retire", wb_if.o_retire, m_valid && !stall);
        if (m_known) begin
            check_eq("rd_addr", wb_if.o_rd_addr, m_addr);
            check_eq("rd_data", wb_if.o_rd_data, m_data);
        end
`ifdef WB_RETIRE_CNT_EN
        check_eq("insn_cnt", wb_if.o_insn_cnt, m_cnt);
`endif
    endtask

    // Drive one cycle's inputs at the falling edge, check the held entry, then
    // advance the model across the rising edge.
    task automatic cycle(input logic stall, input logic flush, input logic valid,
                         input logic wren, input logic [4:0] rd, input logic [1:0] sel,
                         input logic [2:0] f3, input logic [1:0] alo, input logic [31:0] alu,
                         input logic [31:0] ld, input logic [31:0] pc4);
        @(negedge clk);
        wb_if.i_stall    = stall;
        wb_if.i_flush    = flush;
        wb_if.i_valid    = valid;
        wb_if.i_rd_wren  = wren;
        wb_if.i_rd_addr  = rd;
        wb_if.i_wb_sel   = sel;
        wb_if.i_funct3   = f3;
        wb_if.i_addr_lo  = alo;
        wb_if.i_alu_data = alu;
        wb_if.i_ld_data  = ld;
        wb_if.i_pc_four  = pc4;
        #1;
        check_outputs(stall);
        @(posedge clk);
        if (m_valid && !stall) m_cnt = m_cnt + 1;
        if (flush) begin
            m_valid = 0;
            m_known = 0;
        end else if (!stall) begin
            m_valid = valid;
            m_known = 1;
            m_wren  = wren;
            m_addr  = rd;
            m_data  = model_result(sel, f3, alo, alu, ld, pc4);
        end
    endtask

    task automatic bubble();
        cycle(0, 0, 0, 0, 5'd0, 2'd0, 3'd0, 2'd0, 32'd0, 32'd0, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        wb_if.i_stall = 0; wb_if.i_flush = 0; wb_if.i_valid = 0; wb_if.i_rd_wren = 0;
        wb_if.i_rd_addr = '0; wb_if.i_wb_sel = '0; wb_if.i_funct3 = '0; wb_if.i_addr_lo = '0;
        wb_if.i_alu_data = '0; wb_if.i_ld_data = '0; wb_if.i_pc_four = '0;
        model_reset();

        #2;
        check_eq("rst_wren", wb_if.o_rd_wren, 0);
        check_eq("rst_addr", wb_if.o_rd_addr, 0);
        check_eq("rst_data", wb_if.o_rd_data, 0);
        check_eq("rst_retire", wb_if.o_retire, 0);
`ifdef WB_RETIRE_CNT_EN
        check_eq("rst_cnt", wb_if.o_insn_cnt, 0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;

        // LB of the top byte, sign-extended.
        cycle(0, 0, 1, 1, 5'd5, 2'd1, 3'b000, 2'd3, 32'h0, 32'h80FF_1234, 32'h0);
        #1;
        check_eq("lb_wren", wb_if.o_rd_wren, 1);
        check_eq("lb_addr", wb_if.o_rd_addr, 5);
        check_eq("lb_data", wb_if.o_rd_data, 32'hFFFF_FF80);

        cycle(0, 0, 1, 1, 5'd6, 2'd1, 3'b101, 2'd2, 32'h0, 32'h9ABC_0000, 32'h0);
        #1;
        check_eq("lhu_data", wb_if.o_rd_data, 32'h0000_9ABC);
        cycle(0, 0, 1, 1, 5'd6, 2'd1, 3'b001, 2'd2, 32'h0, 32'h9ABC_0000, 32'h0);
        #1;
        check_eq("lh_data", wb_if.o_rd_data, 32'hFFFF_9ABC);

        // JAL to x0: retires but must not write.
        cycle(0, 0, 1, 1, 5'd0, 2'd2, 3'b000, 2'd0, 32'h0, 32'h0, 32'h0000_0104);
        #1;
        check_eq("jal_x0_wren", wb_if.o_rd_wren, 0);
        check_eq("jal_x0_retire", wb_if.o_retire, 1);
        check_eq("jal_x0_data", wb_if.o_rd_data, 32'h0000_0104);

        // ALU op held by three stall cycles; retires only when the stall drops.
        cycle(0, 0, 1, 1, 5'd7, 2'd0, 3'b000, 2'd0, 32'h1234_5678, 32'h0, 32'h0);
        repeat (3) cycle(1, 0, 0, 0, 5'd0, 2'd0, 3'd0, 2'd0, 32'd0, 32'd0, 32'd0);
        #1;
        check_eq("stall_hold_data", wb_if.o_rd_data, 32'h1234_5678);
        bubble();

        // Stall and flush together: flush must win.
        cycle(0, 0, 1, 1, 5'd9, 2'd3, 3'b000, 2'd0, 32'hCAFE_F00D, 32'h0, 32'h0);
        cycle(1, 1, 1, 1, 5'd10, 2'd0, 3'd0, 2'd0, 32'h1, 32'h0, 32'h0);
        #1;
        check_eq("flush_wren", wb_if.o_rd_wren, 0);
        check_eq("flush_retire", wb_if.o_retire, 0);
        bubble();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 4) != 0), 1'($urandom), 5'($urandom), 2'($urandom),
                  3'($urandom), 2'($urandom), $urandom, $urandom, $urandom);
        end

        // Asynchronous reset mid-cycle while a write is pending.
        cycle(0, 0, 1, 1, 5'd11, 2'd0, 3'd0, 2'd0, 32'hDEAD_BEEF, 32'h0, 32'h0);
        #1;
        check_eq("pre_rst_wren", wb_if.o_rd_wren, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_wren", wb_if.o_rd_wren, 0);
        check_eq("async_rst_addr", wb_if.o_rd_addr, 0);
        check_eq("async_rst_data", wb_if.o_rd_data, 0);
        check_eq("async_rst_retire", wb_if.o_retire, 0);
`ifdef WB_RETIRE_CNT_EN
        check_eq("async_rst_cnt", wb_if.o_insn_cnt, 0);
`endif
        model_reset();
        @(posedge clk); #1;
        check_eq("rst_hold_data", wb_if.o_rd_data, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 40; i++) begin
            cycle(($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0), 1'b1,
                  1'b1, 5'($urandom), 2'($urandom), 3'($urandom), 2'($urandom),
                  $urandom, $urandom, $urandom);
        end
        bubble();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
